coreriscv_axi4_gateway_array: RTL and testbench
===============================================

# coreriscv_axi4_gateway_array

Parametrised interrupt gateway array sitting between external interrupt sources and the PLIC in the CoreRISCV AXI4 subsystem. Each of N channels converts a raw interrupt into a single-claim PLIC request, selectable per channel as level-triggered or edge-triggered. Edge mode keeps a saturating pending count so back-to-back edges are not lost. Optional input synchronisers cover asynchronous sources.

## Interface
- `NUM_CH`, 8: number of interrupt channels, 1..64.
- `SYNC_STAGES`, 2: synchroniser flops per input, 0..3; 0 means the input is used directly.
- `CNT_W`, 3: edge pending counter width, 1..8; saturates at 2^CNT_W-1.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; asserts immediately, released synchronously by the system.
- `io_interrupt` input NUM_CH: raw interrupt sources.
- `io_mode` input NUM_CH: per-channel mode, 0 = level, 1 = edge; quasi-static configuration.
- `io_enable` input NUM_CH: per-channel enable.
- `io_plic_valid` output NUM_CH: request to PLIC.
- `io_plic_ready` input NUM_CH: PLIC accepts (claim handshake).
- `io_plic_complete` input NUM_CH: PLIC completion pulse.
- `io_pending` output NUM_CH*CNT_W: per-channel edge pending counts, for debug/CSR readback.

## Operation
- Per channel: `int_s` = `io_interrupt` after SYNC_STAGES flops; `prev` = `int_s` delayed one cycle; `inFlight` flag; `pend` counter.
- Claim = `io_plic_valid & io_plic_ready` on the same channel and cycle.
- `inFlight` next = (`inFlight` & ~`complete`) | claim. Complete while not in flight is ignored. Claim only occurs with `inFlight`=0, so there is no set/clear conflict.
- Level mode: `valid` = `enable` & `int_s` & ~`inFlight`. `pend` is held at 0.
- Edge mode: edge = `int_s` & ~`prev` & `enable`. `pend` next = `pend` + edge - claim. Saturates at max: an edge at max is dropped. Edge and claim together at max leaves max. Edge and claim together otherwise leaves the count unchanged.
- Edge mode: `valid` = `enable` & (`pend` != 0) & ~`inFlight`.
- Disabled channel: `valid` = 0 and edges are not counted. Existing `pend` is retained. `inFlight` still clears on complete.
- Mode change (registered copy of `io_mode` differs from input): `pend` is cleared that cycle and `inFlight` is kept. `prev` keeps tracking.
- Channels are fully independent; no arbitration happens here (the PLIC prioritises).

## Timing
- Reset: `io_plic_valid` = 0, `io_pending` = 0; `inFlight`, `prev`, sync flops and mode register all cleared.
- `io_plic_valid` is combinational from registered state, `io_enable` and `io_mode`. With SYNC_STAGES=0 it is also combinational from `io_interrupt`.
- Level latency, input to valid: SYNC_STAGES cycles.
- Edge latency, rising input to valid: SYNC_STAGES+1 cycles, since the count registers first.
- After claim, valid drops the next cycle. After complete, valid may reassert the next cycle if the condition holds.
- Reset mid-operation discards all pending counts and in-flight state with no completion required.

## Structure
- Shared package `coreriscv_axi4_gateway_pkg`:
  - mode encodings `GW_MODE_LEVEL`=0, `GW_MODE_EDGE`=1;
  - parameter range limits.
- One sub-module, `coreriscv_axi4_gateway_channel`, holds the sync chain, edge detect, `pend`, `inFlight` and mode register. It is generated NUM_CH times; the top level only slices the buses.

## Test plan
- Level channel 0, SYNC_STAGES=2: hold interrupt high. Valid rises 2 cycles later. Ready pulse drops valid next cycle and valid stays low. Complete pulse reasserts valid next cycle. Drop the interrupt and valid falls after 2 cycles.
- Edge channel 3, CNT_W=3: 9 rising edges with no ready. `pend` reaches 7 and stays at 7. Then 7 claim/complete cycles give exactly 7 claims, after which `pend`=0 and valid=0.
- Edge channel: an edge in the same cycle as a claim with `pend`=2 leaves `pend`=2.
- Simultaneous claim on channel 1 and complete on channel 2 in one cycle: each behaves independently, with no cross-effect.
- Disable channel 4 while `pend`=3: valid=0 and further edges are not counted. Re-enable: valid returns and `pend`=3. Flip mode to level: `pend` clears to 0.
- Assert reset mid-flight with `inFlight`=1 and `pend`=5: all outputs go to 0 immediately, asynchronously. After release, a level-high interrupt requests again with no complete needed.

Source files
------------

// File: rtl/coreriscv_axi4_gateway_pkg.sv
// Shared definitions for the CoreRISCV AXI4 interrupt gateway array.
// Holds the per-channel mode encoding and the legal parameter ranges.
package coreriscv_axi4_gateway_pkg;

  typedef enum logic {
    GW_MODE_LEVEL = 1'b0,
    GW_MODE_EDGE  = 1'b1
  } gw_mode_e;

  // Supported parameter ranges
  localparam int GW_NUM_CH_MIN      = 1;
  localparam int GW_NUM_CH_MAX      = 64;
  localparam int GW_SYNC_STAGES_MIN = 0;
  localparam int GW_SYNC_STAGES_MAX = 3;
  localparam int GW_CNT_W_MIN       = 1;
  localparam int GW_CNT_W_MAX       = 8;

endpackage

// File: rtl/coreriscv_axi4_gateway_channel.sv
// Single interrupt gateway channel: optional input synchroniser, edge
// detector, saturating edge-pending counter, in-flight flag and mode register.
// Ports:
//   clk, reset        clock / async active-low reset
//   interrupt         raw interrupt source
//   mode              0 = level, 1 = edge (quasi-static)
//   enable            channel enable
//   plic_valid        request to PLIC
//   plic_ready        PLIC claim accept
//   plic_complete     PLIC completion pulse
//   pending           edge pending count
module coreriscv_axi4_gateway_channel
  import coreriscv_axi4_gateway_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             interrupt,
  input  logic             mode,
  input  logic             enable,
  output logic             plic_valid,
  input  logic             plic_ready,
  input  logic             plic_complete,
  output logic [CNT_W-1:0] pending
);

  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

  logic             int_s;
  logic             prev_q;
  logic             in_flight_q;
  logic             mode_q;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_d;
  logic             edge_mode;
  logic             edge_det;
  logic             claim;
  logic             mode_chg;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign int_s = interrupt;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_pipe;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_pipe <= '0;
        end else begin
          sync_pipe[0] <= interrupt;
          for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
        end
      end
      assign int_s = sync_pipe[SYNC_STAGES-1];
    end
  endgenerate

  assign edge_mode  = (gw_mode_e'(mode) == GW_MODE_EDGE);
  assign mode_chg   = (mode_q != mode);
  // Disabled channels do not count edges; prev keeps tracking regardless.
  assign edge_det   = edge_mode & enable & int_s & ~prev_q;
  assign plic_valid = enable & ~in_flight_q & (edge_mode ? (pend_q != '0) : int_s);
  assign claim      = plic_valid & plic_ready;
  assign pending    = pend_q;

  // Edge+claim cancel out; at max an edge alone is dropped, so edge+claim at
  // max also lands on max via the cancel path.
  always_comb begin
    pend_d = pend_q;
    if (mode_chg || !edge_mode) begin
      pend_d = '0;
    end else if (edge_det && !claim) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + CNT_W'(1);
    end else if (claim && !edge_det) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q      <= 1'b0;
      in_flight_q <= 1'b0;
      mode_q      <= 1'b0;
      pend_q      <= '0;
    end else begin
      prev_q      <= int_s;
      in_flight_q <= (in_flight_q & ~plic_complete) | claim;
      mode_q      <= mode;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: rtl/coreriscv_axi4_gateway_array.sv
// Array of NUM_CH independent interrupt gateways feeding the PLIC.
// Ports (all buses NUM_CH wide, one bit per channel unless noted):
//   clk, reset        clock / async active-low reset
//   io_interrupt      raw interrupt sources
//   io_mode           per-channel mode, 0 = level, 1 = edge
//   io_enable         per-channel enable
//   io_plic_valid     requests to PLIC
//   io_plic_ready     PLIC claim accept
//   io_plic_complete  PLIC completion pulses
//   io_pending        NUM_CH*CNT_W packed edge pending counts, ch0 in LSBs
module coreriscv_axi4_gateway_array
  import coreriscv_axi4_gateway_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       io_interrupt,
  input  logic [NUM_CH-1:0]       io_mode,
  input  logic [NUM_CH-1:0]       io_enable,
  output logic [NUM_CH-1:0]       io_plic_valid,
  input  logic [NUM_CH-1:0]       io_plic_ready,
  input  logic [NUM_CH-1:0]       io_plic_complete,
  output logic [NUM_CH*CNT_W-1:0] io_pending
);

  logic [NUM_CH-1:0][CNT_W-1:0] pend;

  coreriscv_axi4_gateway_channel #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) u_ch [NUM_CH-1:0] (
    .clk          (clk),
    .reset        (reset),
    .interrupt    (io_interrupt),
    .mode         (io_mode),
    .enable       (io_enable),
    .plic_valid   (io_plic_valid),
    .plic_ready   (io_plic_ready),
    .plic_complete(io_plic_complete),
    .pending      (pend)
  );

  assign io_pending = pend;

endmodule

// File: tb/tb_coreriscv_axi4_gateway_array.sv
module tb_coreriscv_axi4_gateway_array;
  localparam int NUM_CH = 8;
  localparam int SYNC   = 2;
  localparam int CNT_W  = 3;
  localparam int PMAX   = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  intr, mode, en, rdy, cmp;
  logic [7:0]  vld;
  logic [23:0] pend;

  always #5 clk = ~clk;

  coreriscv_axi4_gateway_array #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n), .io_interrupt(intr), .io_mode(mode), .io_enable(en),
    .io_plic_valid(vld), .io_plic_ready(rdy), .io_plic_complete(cmp), .io_pending(pend)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_claim3 = 0;

  // Reference model: input history (newest first), counts, in-flight, last mode
  logic [7:0] hist[$];
  int         m_pend[NUM_CH];
  bit         m_infl[NUM_CH];
  bit         m_mode_q[NUM_CH];

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k <= SYNC; k++) hist.push_back(8'h00);
    for (int c = 0; c < NUM_CH; c++) begin
      m_pend[c] = 0; m_infl[c] = 0; m_mode_q[c] = 0;
    end
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en[c] && !m_infl[c])
        v[c] = mode[c] ? (m_pend[c] > 0) : hist[SYNC-1][c];
    end
    return v;
  endfunction

  function automatic logic [23:0] exp_pend();
    logic [23:0] p;
    p = '0;
    for (int c = 0; c < NUM_CH; c++) p[c*CNT_W +: CNT_W] = 3'(m_pend[c]);
    return p;
  endfunction

  function automatic void model_step();
    logic [7:0] ev;
    int p;
    bit cl, e;
    ev = exp_valid();
    for (int c = 0; c < NUM_CH; c++) begin
      cl = ev[c] & rdy[c];
      e  = hist[SYNC-1][c] & ~hist[SYNC][c] & en[c];
      if (mode[c] != m_mode_q[c] || !mode[c]) begin
        m_pend[c] = 0;
      end else begin
        p = m_pend[c] + int'(e) - int'(cl);
        m_pend[c] = (p > PMAX) ? PMAX : p;
      end
      m_infl[c]   = (m_infl[c] & ~cmp[c]) | cl;
      m_mode_q[c] = mode[c];
    end
    hist.push_front(intr);
    void'(hist.pop_back());
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare against model, advance model, cross the rising edge.
  task automatic cycle();
    #1;
    chk("valid", {24'h0, vld}, {24'h0, exp_valid()});
    chk("pending", {8'h0, pend}, {8'h0, exp_pend()});
    if (vld[3] && rdy[3]) n_claim3++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic edges(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      intr[ch] = 1'b1; cycle();
      intr[ch] = 1'b0; cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    intr = '0; rdy = '0; cmp = '0; en = 8'hFF;
    mode = 8'b0011_1000;  // ch3..5 edge, rest level
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {24'h0, vld}, 32'h0);
    chk("reset_pending", {8'h0, pend}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Level channel 0
    intr[0] = 1'b1; cycle();
    chk("lvl_lat1", {31'h0, vld[0]}, 32'h0);
    cycle();
    chk("lvl_lat2", {31'h0, vld[0]}, 32'h1);
    rdy[0] = 1'b1; cycle(); rdy[0] = 1'b0;
    chk("lvl_claim_drop", {31'h0, vld[0]}, 32'h0);
    repeat (3) cycle();
    chk("lvl_stay_low", {31'h0, vld[0]}, 32'h0);
    cmp[0] = 1'b1; cycle(); cmp[0] = 1'b0;
    chk("lvl_reassert", {31'h0, vld[0]}, 32'h1);
    intr[0] = 1'b0; cycle();
    chk("lvl_fall1", {31'h0, vld[0]}, 32'h1);
    cycle();
    chk("lvl_fall2", {31'h0, vld[0]}, 32'h0);

    // Edge channel 3: saturation then drain
    edges(3, 9);
    repeat (4) cycle();
    chk("edge_sat", {29'h0, pend[11:9]}, 32'd7);
    chk("edge_sat_valid", {31'h0, vld[3]}, 32'h1);
    n_claim3 = 0;
    for (int r = 0; r < 10; r++) begin
      rdy[3] = 1'b1; cycle(); rdy[3] = 1'b0;
      cmp[3] = 1'b1; cycle(); cmp[3] = 1'b0;
    end
    chk("edge_claims", n_claim3, 32'd7);
    chk("edge_drained_pend", {29'h0, pend[11:9]}, 32'd0);
    chk("edge_drained_valid", {31'h0, vld[3]}, 32'h0);

    // Edge and claim in the same cycle with pend=2
    edges(3, 2);
    repeat (3) cycle();
    chk("edge_pend2", {29'h0, pend[11:9]}, 32'd2);
    intr[3] = 1'b1; cycle(); cycle();
    rdy[3] = 1'b1; cycle(); rdy[3] = 1'b0;
    chk("edge_claim_same", {29'h0, pend[11:9]}, 32'd2);
    chk("edge_claim_inflight", {31'h0, vld[3]}, 32'h0);
    cmp[3] = 1'b1; cycle(); cmp[3] = 1'b0;
    intr[3] = 1'b0; cycle();

    // Claim ch1 and complete ch2 in the same cycle
    intr[1] = 1'b1; intr[2] = 1'b1;
    repeat (3) cycle();
    chk("indep_both", {30'h0, vld[2:1]}, 32'h3);
    rdy[2] = 1'b1; cycle(); rdy[2] = 1'b0;
    rdy[1] = 1'b1; cmp[2] = 1'b1; cycle(); rdy[1] = 1'b0; cmp[2] = 1'b0;
    chk("indep_ch1", {31'h0, vld[1]}, 32'h0);
    chk("indep_ch2", {31'h0, vld[2]}, 32'h1);
    cmp[1] = 1'b1; cycle(); cmp[1] = 1'b0;
    chk("indep_ch1_back", {31'h0, vld[1]}, 32'h1);
    intr[1] = 1'b0; intr[2] = 1'b0;
    repeat (3) cycle();

    // Disable ch4 with pend=3, re-enable, then flip to level
    edges(4, 3);
    repeat (3) cycle();
    chk("dis_pend3", {29'h0, pend[14:12]}, 32'd3);
    en[4] = 1'b0; #1;
    chk("dis_valid", {31'h0, vld[4]}, 32'h0);
    edges(4, 2);
    repeat (3) cycle();
    chk("dis_no_count", {29'h0, pend[14:12]}, 32'd3);
    en[4] = 1'b1; #1;
    chk("reen_valid", {31'h0, vld[4]}, 32'h1);
    chk("reen_pend", {29'h0, pend[14:12]}, 32'd3);
    mode[4] = 1'b0; cycle();
    chk("mode_flip_clr", {29'h0, pend[14:12]}, 32'd0);

    // Reset mid-flight: ch5 pend=5 in flight, ch0 level in flight
    edges(5, 6);
    repeat (3) cycle();
    rdy[5] = 1'b1; cycle(); rdy[5] = 1'b0;
    chk("rst_pre_pend5", {29'h0, pend[17:15]}, 32'd5);
    chk("rst_pre_infl5", {31'h0, vld[5]}, 32'h0);
    intr[0] = 1'b1; repeat (2) cycle();
    rdy[0] = 1'b1; cycle(); rdy[0] = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {24'h0, vld}, 32'h0);
    chk("rst_async_pending", {8'h0, pend}, 32'h0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) cycle();
    chk("post_reset_level", {31'h0, vld[0]}, 32'h1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      intr = intr ^ 8'($urandom & $urandom);
      rdy  = 8'($urandom);
      cmp  = 8'($urandom & $urandom & $urandom);
      en   = ~8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) mode = mode ^ 8'(1 << $urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
